jt49_env_gen: RTL and testbench

- Envelope generator for the JT49 PSG core.
- Sits directly downstream of the clock-enable prescaler. It consumes the prescaled enable pulse and produces the 5-bit envelope level used by the channel amplitude mixer.
- Implements the AY/YM envelope shapes using:
  - a 16-bit period counter,
  - a 5-bit step counter,
  - a two-state RUN/HOLD machine.

---
 rtl/jt49_env_gen_if.sv | 20 ++
 rtl/jt49_env_gen.sv | 101 ++++++++++
 tb/tb_jt49_env_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jt49_env_gen_if.sv
// Envelope generator control/level bundle: the register side drives the envelope controls,
// and the generator returns the level and the hold flag.
interface jt49_env_gen_if;
  logic        cen;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        restart;
  logic [4:0]  env;
  logic        holding;

  modport master (
    output cen, period, shape, restart,
    input  env, holding
  );

  modport slave (
    input  cen, period, shape, restart,
    output env, holding
  );
endinterface

// File: rtl/jt49_env_gen.sv
// JT49 envelope generator: period counter, step counter and RUN/HOLD machine producing a
// 5-bit level. Define JT49_ENV_16STEP_EN for AY-3-8910 style 16-step resolution.
module jt49_env_gen (
  input  logic            clk,
  input  logic            rst,
  jt49_env_gen_if.slave   bus
);

  typedef enum logic {StRun, StHold} state_e;

`ifdef JT49_ENV_16STEP_EN
  localparam logic [4:0] StepInc = 5'd2;
`else
  localparam logic [4:0] StepInc = 5'd1;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  step_q, step_d;
  logic        inv_q, inv_d;
  logic [4:0]  env_q, env_d;
  logic        holding_q;

  logic [15:0] per;
  logic        tick;
  logic        end_cyc;
  logic [4:0]  lvl;

  always_comb begin
    // A zero period behaves like one; >= lets a lowered period tick immediately.
    per     = (bus.period == 16'd0) ? 16'd1 : bus.period;
    tick    = bus.cen && (state_q == StRun) && (({1'b0, cnt_q} + 17'd1) >= {1'b0, per});
`ifdef JT49_ENV_16STEP_EN
    end_cyc = (step_q[4:1] == 4'hf);
`else
    end_cyc = (step_q == 5'd31);
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    inv_d   = inv_q;

    if (bus.restart) begin
      cnt_d   = 16'd0;
      step_d  = 5'd0;
      inv_d   = ~bus.shape[2];
      state_d = StRun;
    end else if (bus.cen && (state_q == StRun)) begin
      if (!tick) begin
        cnt_d = cnt_q + 16'd1;
      end else begin
        cnt_d = 16'd0;
        if (!end_cyc) begin
          step_d = step_q + StepInc;
        end else if (!bus.shape[3]) begin
          // Every non-continuous shape parks at level 0.
          state_d = StHold;
          inv_d   = 1'b1;
          step_d  = 5'd31;
        end else if (bus.shape[0]) begin
          state_d = StHold;
          step_d  = 5'd31;
          if (bus.shape[1]) inv_d = ~inv_q;
        end else begin
          step_d = 5'd0;
          if (bus.shape[1]) inv_d = ~inv_q;
        end
      end
    end

    lvl = inv_d ? ~step_d : step_d;
`ifdef JT49_ENV_16STEP_EN
    env_d = {lvl[4:1], lvl[4]};
`else
    env_d = lvl;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHold;
      cnt_q     <= 16'd0;
      step_q    <= 5'd0;
      inv_q     <= 1'b0;
      env_q     <= 5'd0;
      holding_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      inv_q     <= inv_d;
      env_q     <= env_d;
      holding_q <= (state_d == StHold);
    end
  end

  assign bus.env     = env_q;
  assign bus.holding = holding_q;

endmodule

// File: tb/tb_jt49_env_gen.sv
// Scoreboard bench for jt49_env_gen (default 32-step build): the driver queues the expected
// level/hold flag after each clock and a negedge monitor pops and compares.
module tb_jt49_env_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt49_env_gen_if bus ();

  jt49_env_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] env;
    logic       hold;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.env !== e.env || bus.holding !== e.hold) begin
        errors++;
        $display("FAIL %s: got env=%0d holding=%0b, expected env=%0d holding=%0b",
                 e.nm, bus.env, bus.holding, e.env, e.hold);
      end
    end
  end

  // Drive one clock of stimulus, then queue the response expected after that edge.
  task automatic cyc(input logic c, input logic r, input logic [4:0] e, input logic h,
                     input string nm);
    exp_t x;
    bus.cen     = c;
    bus.restart = r;
    @(posedge clk);
    #1;
    x.env  = e;
    x.hold = h;
    x.nm   = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    logic [4:0] e;
    int         p;
    bus.cen     = 1'b0;
    bus.restart = 1'b0;
    bus.period  = 16'd1;
    bus.shape   = 4'b0000;

    // Reset, then free-running cen must not move the envelope out of HOLD.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 5'd0, 1'b1, "reset");
    cyc(1'b0, 1'b0, 5'd0, 1'b1, "reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 5'd0, 1'b1, "idle_hold");

    // Rising ramp, continue+hold: 0..31 then parks at 31.
    bus.period = 16'd1;
    bus.shape  = 4'b1101;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, "rise_restart");
    for (int i = 1; i < 32; i++) cyc(1'b1, 1'b0, 5'(i), 1'b0, "rise_ramp");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd31, 1'b1, "rise_hold");

    // Falling one-shot, period 3, cen every 4th clock; parks at 0.
    bus.period = 16'd3;
    bus.shape  = 4'b0000;
    cyc(1'b0, 1'b1, 5'd31, 1'b0, "fall_restart");
    e = 5'd31;
    for (int s = 1; s <= 32; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 2 && s < 32) e = e - 5'd1;
        cyc(1'b1, 1'b0, e, (s == 32 && c == 2), "fall_cen");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, e, (s == 32 && c == 2), "fall_idle");
      end
    end

    // Triangle with period 0 (treated as 1): 64-tick repeating up/down.
    bus.period = 16'd0;
    bus.shape  = 4'b1110;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, "tri_restart");
    for (int t = 1; t <= 200; t++) begin
      p = t % 64;
      cyc(1'b1, 1'b0, (p < 32) ? 5'(p) : 5'(63 - p), 1'b0, "triangle");
    end

    // Restart beats a coincident cen and clears the period counter; rst aborts RUN.
    bus.period = 16'd1;
    bus.shape  = 4'b1101;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, "mid_restart0");
    for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b0, 5'(i), 1'b0, "mid_ramp");
    bus.period = 16'd3;
    bus.shape  = 4'b1000;
    cyc(1'b1, 1'b1, 5'd31, 1'b0, "restart_with_cen");
    cyc(1'b1, 1'b0, 5'd31, 1'b0, "restart_cnt0_a");
    cyc(1'b1, 1'b0, 5'd31, 1'b0, "restart_cnt0_b");
    cyc(1'b1, 1'b0, 5'd30, 1'b0, "restart_cnt0_tick");
    rst = 1'b1;
    cyc(1'b1, 1'b0, 5'd0, 1'b1, "rst_in_run");
    rst = 1'b0;
    cyc(1'b1, 1'b0, 5'd0, 1'b1, "after_rst");

    // Lowering the period mid-count ticks on the next cen, then every 10 cens.
    bus.period = 16'd100;
    bus.shape  = 4'b1101;
    cyc(1'b0, 1'b1, 5'd0, 1'b0, "per_restart");
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 5'd0, 1'b0, "per_count100");
    bus.period = 16'd10;
    cyc(1'b1, 1'b0, 5'd1, 1'b0, "per_lower_tick");
    for (int i = 1; i <= 20; i++)
      cyc(1'b1, 1'b0, (i < 10) ? 5'd1 : ((i < 20) ? 5'd2 : 5'd3), 1'b0, "per_spacing10");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
